// File: rtl/video_dnn_stream_compare.sv
// Pixel-wise join of a reference and a DUT classification stream: emits a 1-bit
// mismatch stream plus per-frame pixel/mismatch statistics and a sticky sync error.
module video_dnn_stream_compare #(
    parameter int TUSER_WIDTH = 1,
    parameter int TDATA_WIDTH = 11,
    parameter int COUNT_WIDTH = 20
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [TUSER_WIDTH-1:0] s_ref_tuser,
    input  logic                   s_ref_tlast,
    input  logic [TDATA_WIDTH-1:0] s_ref_tdata,
    input  logic                   s_ref_tvalid,
    output logic                   s_ref_tready,
    input  logic [TUSER_WIDTH-1:0] s_dut_tuser,
    input  logic                   s_dut_tlast,
    input  logic [TDATA_WIDTH-1:0] s_dut_tdata,
    input  logic                   s_dut_tvalid,
    output logic                   s_dut_tready,
    output logic [TUSER_WIDTH-1:0] m_axi4s_tuser,
    output logic                   m_axi4s_tlast,
    output logic                   m_axi4s_tdata,
    output logic                   m_axi4s_tvalid,
    input  logic                   m_axi4s_tready,
    output logic [COUNT_WIDTH-1:0] frame_pix_count,
    output logic [COUNT_WIDTH-1:0] frame_err_count,
    output logic                   frame_done,
    output logic                   frame_valid,
    output logic                   sync_err
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic                   can_load;
    logic                   accept;
    logic                   mismatch;
    logic                   frame_started;
    logic [COUNT_WIDTH-1:0] pix_run;
    logic [COUNT_WIDTH-1:0] err_run;

    // The output slot is free when empty or draining this cycle; gating with aresetn
    // keeps both readies low while reset is held.
    assign can_load     = aresetn && (!m_axi4s_tvalid || m_axi4s_tready);
    assign s_ref_tready = can_load && s_dut_tvalid;
    assign s_dut_tready = can_load && s_ref_tvalid;
    assign accept       = can_load && s_ref_tvalid && s_dut_tvalid;
    assign mismatch     = (s_ref_tdata != s_dut_tdata);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value,
                                                       input logic inc);
        return (inc && value != CNT_MAX) ? value + COUNT_WIDTH'(1) : value;
    endfunction

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axi4s_tuser  <= '0;
            m_axi4s_tlast  <= 1'b0;
            m_axi4s_tdata  <= 1'b0;
            m_axi4s_tvalid <= 1'b0;
        end else if (accept) begin
            m_axi4s_tuser  <= s_ref_tuser;
            m_axi4s_tlast  <= s_ref_tlast;
            m_axi4s_tdata  <= mismatch;
            m_axi4s_tvalid <= 1'b1;
        end else if (m_axi4s_tready) begin
            m_axi4s_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pix_run         <= '0;
            err_run         <= '0;
            frame_started   <= 1'b0;
            frame_pix_count <= '0;
            frame_err_count <= '0;
            frame_done      <= 1'b0;
            frame_valid     <= 1'b0;
            sync_err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                if (s_ref_tuser[0] != s_dut_tuser[0] || s_ref_tlast != s_dut_tlast)
                    sync_err <= 1'b1;
                if (s_ref_tuser[0]) begin
                    // Publish the closing frame (saturated or not) before restarting.
                    if (frame_started) begin
                        frame_pix_count <= pix_run;
                        frame_err_count <= err_run;
                        frame_done      <= 1'b1;
                        frame_valid     <= 1'b1;
                    end
                    pix_run       <= COUNT_WIDTH'(1);
                    err_run       <= COUNT_WIDTH'(mismatch);
                    frame_started <= 1'b1;
                end else if (frame_started) begin
                    pix_run <= sat_inc(pix_run, 1'b1);
                    err_run <= sat_inc(err_run, mismatch);
                end
            end
        end
    end

endmodule

// File: tb/tb_video_dnn_stream_compare.sv
// Randomized bench for video_dnn_stream_compare: beat queues drive both streams and a
// transaction-level scoreboard predicts the mismatch stream and frame statistics.
module tb_video_dnn_stream_compare;

    localparam int TD     = 11;
    localparam int MAX_L  = (1 << 20) - 1;
    localparam int MAX_S  = (1 << 4) - 1;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [0:0]    s_ref_tuser, s_dut_tuser;
    logic          s_ref_tlast, s_dut_tlast;
    logic [TD-1:0] s_ref_tdata, s_dut_tdata;
    logic          s_ref_tvalid, s_dut_tvalid;
    logic          s_ref_tready, s_dut_tready, s_ref_tready_s, s_dut_tready_s;
    logic [0:0]    m_tuser, m_tuser_s;
    logic          m_tlast, m_tdata, m_tvalid, m_tlast_s, m_tdata_s, m_tvalid_s;
    logic          m_tready;
    logic [19:0]   fpc, fec;
    logic [3:0]    fpc_s, fec_s;
    logic          fdone, fvalid, serr, fdone_s, fvalid_s, serr_s;

    always #5 aclk = ~aclk;

    video_dnn_stream_compare dut_l (
        .aclk(aclk), .aresetn(aresetn),
        .s_ref_tuser(s_ref_tuser), .s_ref_tlast(s_ref_tlast), .s_ref_tdata(s_ref_tdata),
        .s_ref_tvalid(s_ref_tvalid), .s_ref_tready(s_ref_tready),
        .s_dut_tuser(s_dut_tuser), .s_dut_tlast(s_dut_tlast), .s_dut_tdata(s_dut_tdata),
        .s_dut_tvalid(s_dut_tvalid), .s_dut_tready(s_dut_tready),
        .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tdata(m_tdata),
        .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready),
        .frame_pix_count(fpc), .frame_err_count(fec), .frame_done(fdone),
        .frame_valid(fvalid), .sync_err(serr)
    );

    video_dnn_stream_compare #(.COUNT_WIDTH(4)) dut_s (
        .aclk(aclk), .aresetn(aresetn),
        .s_ref_tuser(s_ref_tuser), .s_ref_tlast(s_ref_tlast), .s_ref_tdata(s_ref_tdata),
        .s_ref_tvalid(s_ref_tvalid), .s_ref_tready(s_ref_tready_s),
        .s_dut_tuser(s_dut_tuser), .s_dut_tlast(s_dut_tlast), .s_dut_tdata(s_dut_tdata),
        .s_dut_tvalid(s_dut_tvalid), .s_dut_tready(s_dut_tready_s),
        .m_axi4s_tuser(m_tuser_s), .m_axi4s_tlast(m_tlast_s), .m_axi4s_tdata(m_tdata_s),
        .m_axi4s_tvalid(m_tvalid_s), .m_axi4s_tready(m_tready),
        .frame_pix_count(fpc_s), .frame_err_count(fec_s), .frame_done(fdone_s),
        .frame_valid(fvalid_s), .sync_err(serr_s)
    );

    typedef struct packed {
        logic          user;
        logic          last;
        logic [TD-1:0] data;
    } beat_t;

    typedef struct packed {
        logic user;
        logic last;
        logic mis;
    } out_t;

    beat_t ref_q[$];
    beat_t dut_q[$];
    out_t  exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int vmode  = 0;
    int rmode  = 0;

    // Scoreboard: running frame totals per counter width plus the values visible now.
    bit          started;
    int unsigned pix_l, err_l, pix_s, err_s;
    int unsigned e_pix_l, e_err_l, e_pix_s, e_err_s;
    bit          e_done, e_fvalid, e_sync;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        started = 0;
        pix_l = 0; err_l = 0; pix_s = 0; err_s = 0;
        e_pix_l = 0; e_err_l = 0; e_pix_s = 0; e_err_s = 0;
        e_done = 0; e_fvalid = 0; e_sync = 0;
    endtask

    task automatic push_frame(input int w, input int h, input int mis_mode, input bit shift_last);
        for (int p = 0; p < w * h; p++) begin
            beat_t r, d;
            bit    mis;
            r.user = (p == 0);
            r.last = ((p % w) == w - 1);
            r.data = TD'($urandom);
            case (mis_mode)
                1:       mis = (p == 0 || p == 5 || p == 11);
                2:       mis = 1;
                3:       mis = ($urandom_range(0, 3) == 0);
                default: mis = 0;
            endcase
            d = r;
            if (mis) d.data = r.data ^ TD'($urandom_range(1, 2047));
            if (shift_last) d.last = ((p % w) == w - 2);
            ref_q.push_back(r);
            dut_q.push_back(d);
        end
    endtask

    task automatic drive();
        bit rg, dg;
        rg = (vmode == 2) ? bit'($urandom_range(0, 1)) : 1'b1;
        dg = (vmode == 1) ? bit'(cyc % 2) : (vmode == 2) ? bit'($urandom_range(0, 1)) : 1'b1;
        s_ref_tvalid = (ref_q.size() != 0) && rg;
        s_dut_tvalid = (dut_q.size() != 0) && dg;
        if (ref_q.size() != 0) begin
            {s_ref_tuser, s_ref_tlast, s_ref_tdata} = ref_q[0];
            {s_dut_tuser, s_dut_tlast, s_dut_tdata} = dut_q[0];
        end else begin
            {s_ref_tuser, s_ref_tlast, s_ref_tdata} = '0;
            {s_dut_tuser, s_dut_tlast, s_dut_tdata} = '0;
        end
        m_tready = (rmode == 1) ? bit'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic check_and_predict();
        bit    can_load;
        beat_t r, d;
        out_t  o;
        check("m_valid", m_tvalid, 32'(exp_q.size() != 0));
        check("m_valid_s", m_tvalid_s, 32'(exp_q.size() != 0));
        if (exp_q.size() != 0 && m_tvalid) begin
            check("m_tdata", m_tdata, exp_q[0].mis);
            check("m_tuser", m_tuser, exp_q[0].user);
            check("m_tlast", m_tlast, exp_q[0].last);
        end
        check("frame_done", fdone, e_done);
        check("frame_pix", fpc, e_pix_l);
        check("frame_err", fec, e_err_l);
        check("frame_valid", fvalid, e_fvalid);
        check("sync_err", serr, e_sync);
        check("frame_done_s", fdone_s, e_done);
        check("frame_pix_s", fpc_s, e_pix_s);
        check("frame_err_s", fec_s, e_err_s);

        can_load = (exp_q.size() == 0) || m_tready;
        check("ref_ready", s_ref_tready, 32'(aresetn && s_dut_tvalid && can_load));
        check("dut_ready", s_dut_tready, 32'(aresetn && s_ref_tvalid && can_load));
        check("ref_ready_s", s_ref_tready_s, 32'(aresetn && s_dut_tvalid && can_load));

        if (exp_q.size() != 0 && m_tready) void'(exp_q.pop_front());
        e_done = 0;
        if (!aresetn) begin
            model_reset();
        end else if (s_ref_tvalid && s_dut_tvalid && can_load) begin
            r = ref_q.pop_front();
            d = dut_q.pop_front();
            o.user = r.user;
            o.last = r.last;
            o.mis  = (r.data != d.data);
            exp_q.push_back(o);
            if (r.user != d.user || r.last != d.last) e_sync = 1;
            if (r.user) begin
                if (started) begin
                    e_pix_l = pix_l; e_err_l = err_l;
                    e_pix_s = pix_s; e_err_s = err_s;
                    e_done = 1; e_fvalid = 1;
                end
                pix_l = 1; err_l = o.mis; pix_s = 1; err_s = o.mis;
                started = 1;
            end else if (started) begin
                pix_l = sat(pix_l + 1, MAX_L); err_l = sat(err_l + o.mis, MAX_L);
                pix_s = sat(pix_s + 1, MAX_S); err_s = sat(err_s + o.mis, MAX_S);
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge aclk);
        check_and_predict();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic run(input int vm, input int rm);
        int n = 0;
        vmode = vm;
        rmode = rm;
        while ((ref_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
            step();
            n++;
        end
        check("drain", 32'(ref_q.size() + exp_q.size()), 0);
        rmode = 0;
        repeat (2) step();
    endtask

    initial begin
        model_reset();
        {s_ref_tuser, s_ref_tlast, s_ref_tdata, s_ref_tvalid} = '0;
        {s_dut_tuser, s_dut_tlast, s_dut_tdata, s_dut_tvalid} = '0;
        m_tready = 1'b1;
        @(posedge aclk);
        #1;
        repeat (3) step();
        aresetn = 1'b1;

        // Identical streams, two 4x3 frames, then a lone frame start to close frame 2.
        push_frame(4, 3, 0, 0); push_frame(4, 3, 0, 0); push_frame(1, 1, 0, 0);
        run(0, 0);
        check("id_pix", fpc, 12); check("id_err", fec, 0);
        check("id_valid", fvalid, 1); check("id_sync", serr, 0);

        // Mismatches on pixels 0, 5 and 11.
        push_frame(4, 3, 1, 0); push_frame(1, 1, 0, 0);
        run(0, 0);
        check("mis_err", fec, 3); check("mis_pix", fpc, 12);

        // DUT valid every other cycle.
        push_frame(4, 3, 0, 0); push_frame(4, 3, 0, 0); push_frame(1, 1, 0, 0);
        run(1, 0);
        check("alt_pix", fpc, 12); check("alt_err", fec, 0);

        // Random valids, random back-pressure, random mismatches.
        for (int f = 0; f < 6; f++)
            push_frame($urandom_range(2, 6), $urandom_range(1, 4), 3, 0);
        push_frame(1, 1, 0, 0);
        run(2, 1);

        // DUT tlast one pixel early: sticky sync error.
        push_frame(4, 3, 0, 1); push_frame(4, 3, 0, 0); push_frame(1, 1, 0, 0);
        run(0, 1);
        check("sync_sticky", serr, 1);

        // 20-pixel frame, every pixel mismatched: 4-bit counters saturate.
        push_frame(5, 4, 2, 0); push_frame(1, 1, 0, 0);
        run(0, 0);
        check("sat_pix_s", fpc_s, 15); check("sat_err_s", fec_s, 15);
        check("sat_pix_l", fpc, 20); check("sat_err_l", fec, 20);

        // Reset mid-frame; the next frame start must not pulse frame_done.
        push_frame(4, 3, 1, 0);
        vmode = 0;
        repeat (6) step();
        aresetn = 1'b0;
        repeat (2) step();
        aresetn = 1'b1;
        check("rst_valid", fvalid, 0); check("rst_pix", fpc, 0);
        check("rst_mvalid", m_tvalid, 0); check("rst_sync", serr, 0);
        push_frame(3, 2, 3, 0); push_frame(4, 2, 0, 0); push_frame(1, 1, 0, 0);
        run(2, 1);
        check("post_rst_pix", fpc, 8); check("post_rst_err", fec, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
